stream_bram_wr: RTL and testbench

STREAM_BRAM_WR -- requirements
Module: stream_bram_wr

---
 rtl/stream_bram_pkg.sv | 13 +
 rtl/bank_ctrl.sv | 34 +++
 rtl/stream_bram_wr.sv | 92 +++++++++
 tb/tb_stream_bram_wr.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_bram_pkg.sv
// Shared types and defaults for the stream-to-BRAM writer.
// Bank flags and default geometry live here.
package stream_bram_pkg;

  typedef enum logic {
    FREE = 1'b0,
    FULL = 1'b1
  } bank_state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 1024;

endpackage

// File: rtl/bank_ctrl.sv
// Two-bank FREE/FULL flags with close/release arbitration.
// A close and a release of the same bank on one edge leave it FULL.
module bank_ctrl
  import stream_bram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              close_vld,
  input  logic              close_bank,
  input  logic              rel_valid,
  input  logic              rel_bank,
  output bank_state_t [1:0] flag
);

  bank_state_t [1:0] flag_nxt;

  always_comb begin
    flag_nxt = flag;
    for (int b = 0; b < 2; b++) begin
      if (close_vld && close_bank == 1'(b))
        flag_nxt[b] = FULL;
      else if (rel_valid && rel_bank == 1'(b))
        flag_nxt[b] = FREE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      flag <= {FREE, FREE};
    else
      flag <= flag_nxt;
  end

endmodule

// File: rtl/stream_bram_wr.sv
// Ping-pong writer: stream frames into two BRAM banks.
// Each closed frame is handed over via buf_done/buf_bank/buf_len.
module stream_bram_wr
  import stream_bram_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  output logic             s_tready,
  output logic             bram_en,
  output logic             bram_we,
  output logic [AW-1:0]    bram_addr,
  output logic [WIDTH-1:0] bram_din,
  output logic             buf_done,
  output logic             buf_bank,
  output logic [AW-1:0]    buf_len,
  input  logic             rel_valid,
  input  logic             rel_bank,
  output logic             len_err,
  output logic [15:0]      frame_cnt
);

  localparam int PW = AW - 1;

  bank_state_t [1:0] flag;
  logic              rdy_en;
  logic              wbank;
  logic [PW-1:0]     wptr;
  logic              hs;
  logic              at_end;
  logic              close;

  // rdy_en keeps s_tready low until the first edge after reset
  assign s_tready = rdy_en & (flag[wbank] == FREE);
  assign hs       = s_tvalid & s_tready;
  assign at_end   = (wptr == PW'(DEPTH - 1));
  assign close    = hs & (s_tlast | at_end);

  bank_ctrl u_bank_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .close_vld  (close),
    .close_bank (wbank),
    .rel_valid  (rel_valid),
    .rel_bank   (rel_bank),
    .flag       (flag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en    <= 1'b0;
      wbank     <= 1'b0;
      wptr      <= '0;
      bram_en   <= 1'b0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      buf_done  <= 1'b0;
      buf_bank  <= 1'b0;
      buf_len   <= '0;
      len_err   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      rdy_en   <= 1'b1;
      bram_en  <= hs;
      bram_we  <= hs;
      buf_done <= close;
      if (hs) begin
        bram_addr <= {wbank, wptr};
        bram_din  <= s_tdata;
      end
      if (close) begin
        buf_bank  <= wbank;
        buf_len   <= {1'b0, wptr} + AW'(1);
        wbank     <= ~wbank;
        wptr      <= '0;
        frame_cnt <= frame_cnt + 16'd1;
        if (!s_tlast)
          len_err <= 1'b1;
      end else if (hs) begin
        wptr <= wptr + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_stream_bram_wr.sv
// Randomized bench for stream_bram_wr against a frame-level model.
// WIDTH=32, DEPTH=16.
module tb_stream_bram_wr;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [W-1:0]  s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic          bram_en;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [W-1:0]  bram_din;
  logic          buf_done;
  logic          buf_bank;
  logic [AW-1:0] buf_len;
  logic          rel_valid = 1'b0;
  logic          rel_bank = 1'b0;
  logic          len_err;
  logic [15:0]   frame_cnt;

  stream_bram_wr #(.WIDTH(W), .DEPTH(D), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
    .bram_en   (bram_en),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .buf_done  (buf_done),
    .buf_bank  (buf_bank),
    .buf_len   (buf_len),
    .rel_valid (rel_valid),
    .rel_bank  (rel_bank),
    .len_err   (len_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // frame-level model
  bit        full_m [2];
  bit        wb_m;
  int        wp_m;
  bit        rdy_m;
  bit        lerr_m;
  logic [15:0] frm_m;
  int        blen_m;
  bit        bbank_m;
  bit        hs_q;

  task automatic model_reset();
    full_m[0] = 0; full_m[1] = 0;
    wb_m = 0; wp_m = 0; rdy_m = 0; lerr_m = 0;
    frm_m = 0; blen_m = 0; bbank_m = 0; hs_q = 0;
  endtask

  task automatic tick();
    bit hs, cl, ready;
    int ea;
    logic [31:0] ed;
    ready = rdy_m && !full_m[wb_m];
    chk("s_tready", s_tready, ready);
    hs = s_tvalid && ready;
    cl = 0; ea = 0; ed = s_tdata;
    if (hs) begin
      ea = wb_m * D + wp_m;
      cl = s_tlast || (wp_m == D - 1);
      if (cl) begin
        if (!s_tlast) lerr_m = 1;
        bbank_m = wb_m;
        blen_m  = wp_m + 1;
      end
    end
    if (rel_valid && !(cl && rel_bank == wb_m)) full_m[rel_bank] = 0;
    if (cl) begin
      full_m[wb_m] = 1;
      wb_m = !wb_m;
      wp_m = 0;
      frm_m = frm_m + 16'd1;
    end else if (hs) begin
      wp_m++;
    end
    rdy_m = 1;
    @(posedge clk);
    #1;
    chk("bram_en", bram_en, hs);
    chk("bram_we", bram_we, hs);
    if (hs) begin
      chk("bram_addr", bram_addr, ea);
      chk("bram_din", bram_din, ed);
    end
    chk("buf_done", buf_done, cl);
    chk("buf_bank", buf_bank, bbank_m);
    chk("buf_len", buf_len, blen_m);
    chk("len_err", len_err, lerr_m);
    chk("frame_cnt", frame_cnt, frm_m);
    hs_q = hs;
    @(negedge clk);
  endtask

  task automatic push(logic [31:0] d, bit last, bit rv, bit rb);
    int n;
    n = 0;
    s_tdata = d; s_tlast = last; s_tvalid = 1;
    rel_valid = rv; rel_bank = rb;
    do begin
      tick();
      n++;
    end while (!hs_q && n < 64);
    if (!hs_q) chk("push_timeout", 0, 1);
    s_tvalid = 0; s_tlast = 0; rel_valid = 0;
  endtask

  task automatic do_reset();
    s_tvalid = 0; s_tlast = 0; s_tdata = 0;
    rel_valid = 0; rel_bank = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_ready", s_tready, 0);
    chk("rst_en", bram_en, 0);
    chk("rst_we", bram_we, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_din", bram_din, 0);
    chk("rst_done", buf_done, 0);
    chk("rst_bank", buf_bank, 0);
    chk("rst_len", buf_len, 0);
    chk("rst_lerr", len_err, 0);
    chk("rst_fcnt", frame_cnt, 0);
    model_reset();
    @(posedge clk);
    #1 chk("rst_ready_hold", s_tready, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  int acc;

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // 8-word frame, then next frame in bank 1
    for (int i = 0; i < 8; i++) push(i, i == 7, 0, 0);
    chk("f1_ready", s_tready, 1);
    for (int i = 0; i < 3; i++) push(100 + i, 0, 0, 0);

    // two full frames, stall, release bank 0
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < D; i++) push(f * 64 + i, i == D - 1, 0, 0);
    s_tvalid = 1; s_tdata = 32'hAAAA_0001; s_tlast = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("stall_ready", s_tready, 0);
    rel_valid = 1; rel_bank = 0;
    tick();
    rel_valid = 0;
    tick();
    chk("resume_hs", hs_q, 1);
    s_tvalid = 0;

    // overlong frame
    do_reset();
    for (int i = 1; i <= 20; i++) push(32'h200 + i, 0, 0, 0);
    chk("len_err_sticky", len_err, 1);

    // release of bank 0 while bank 1 closes
    do_reset();
    for (int i = 0; i < 3; i++) push(32'h300 + i, i == 2, 0, 0);
    push(32'h310, 0, 0, 0);
    push(32'h311, 0, 0, 0);
    push(32'h312, 1, 1, 0);
    chk("coinc_ready", s_tready, 1);
    for (int i = 0; i < 3; i++) push(32'h320 + i, 0, 0, 0);

    // random gaps, tlast every 5 accepted words
    do_reset();
    acc = 0;
    for (int c = 0; c < 400; c++) begin
      s_tvalid  = ($urandom_range(0, 3) != 0);
      s_tdata   = $urandom;
      s_tlast   = (acc % 5 == 4);
      rel_valid = ($urandom_range(0, 5) == 0);
      rel_bank  = 1'($urandom_range(0, 1));
      tick();
      if (hs_q) acc++;
    end
    s_tvalid = 0; rel_valid = 0;
    tick();
    chk("rand_frames", frame_cnt, acc / 5);

    // reset mid-frame
    do_reset();
    for (int i = 0; i < 3; i++) push(32'h400 + i, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h500 + i, i == 3, 0, 0);
    chk("post_rst_frames", frame_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
